// File: rtl/vending_pkg.sv
// Shared coin constants, credit encodings and change-FSM state type for the
// vending return path.
package vending_pkg;

  localparam logic [5:0] NICKEL  = 6'd5;
  localparam logic [5:0] DIME    = 6'd10;
  localparam logic [5:0] QUARTER = 6'd25;

  localparam logic [5:0] CREDIT_ZERO       = 6'd0;
  localparam logic [5:0] CREDIT_FIVE       = 6'd5;
  localparam logic [5:0] CREDIT_TEN        = 6'd10;
  localparam logic [5:0] CREDIT_FIFTEEN    = 6'd15;
  localparam logic [5:0] CREDIT_TWENTY     = 6'd20;
  localparam logic [5:0] CREDIT_TWENTYFIVE = 6'd25;
  localparam logic [5:0] CREDIT_THIRTY     = 6'd30;
  localparam logic [5:0] CREDIT_THIRTYFIVE = 6'd35;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DISPENSE,
    S_DONE,
    S_FAULT
  } chg_state_t;

  function automatic logic is_legal_credit(input logic [5:0] c);
    case (c)
      CREDIT_ZERO, CREDIT_FIVE, CREDIT_TEN, CREDIT_FIFTEEN,
      CREDIT_TWENTY, CREDIT_TWENTYFIVE, CREDIT_THIRTY,
      CREDIT_THIRTYFIVE: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three per-denomination coin counters with bulk reload and single decrement;
// a reload in the same cycle as a payout still charges the dispensed coin.
module coin_inventory #(
  parameter int MAX_COINS  = 15,
  parameter int INIT_COINS = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill,
  input  logic             dec_q,
  input  logic             dec_d,
  input  logic             dec_n,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_COINS);
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_COINS);

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                 input logic             reload,
                                                 input logic             dec);
    logic [CNT_W-1:0] base;
    base = reload ? MAX_V : cur;
    return dec ? base - 1'b1 : base;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt <= INIT_V;
      d_cnt <= INIT_V;
      n_cnt <= INIT_V;
    end else begin
      q_cnt <= next_cnt(q_cnt, refill, dec_q);
      d_cnt <= next_cnt(d_cnt, refill, dec_d);
      n_cnt <= next_cnt(n_cnt, refill, dec_n);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change-return FSM: pays a residual credit as quarters, dimes and
// nickels, one coin per req/ack handshake, faulting when inventory runs short.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int MAX_COINS  = 15,
  parameter int INIT_COINS = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       credit,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             req_q,
  output logic             req_d,
  output logic             req_n,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [5:0]       remaining,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt
);

  chg_state_t state;
  logic [5:0] coin_value;
  logic       ack_ok;

  assign busy   = (state != S_IDLE);
  assign ack_ok = (state == S_DISPENSE) && coin_ack;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    coin_value = NICKEL;
    if (req_q)      coin_value = QUARTER;
    else if (req_d) coin_value = DIME;
  end

  coin_inventory #(
    .MAX_COINS (MAX_COINS),
    .INIT_COINS(INIT_COINS),
    .CNT_W     (CNT_W)
  ) u_inventory (
    .clk   (clk),
    .reset (reset),
    .refill(refill),
    .dec_q (ack_ok && req_q),
    .dec_d (ack_ok && req_d),
    .dec_n (ack_ok && req_n),
    .q_cnt (q_cnt),
    .d_cnt (d_cnt),
    .n_cnt (n_cnt)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      req_d     <= 1'b0;
      req_n     <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= is_legal_credit(credit) ? credit : CREDIT_THIRTYFIVE;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          // Largest coin first, skipping any denomination that is out of stock.
          if (remaining == 6'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (remaining >= QUARTER && q_cnt != '0) begin
            req_q <= 1'b1;
            state <= S_DISPENSE;
          end else if (remaining >= DIME && d_cnt != '0) begin
            req_d <= 1'b1;
            state <= S_DISPENSE;
          end else if (remaining >= NICKEL && n_cnt != '0) begin
            req_n <= 1'b1;
            state <= S_DISPENSE;
          end else begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_DISPENSE: begin
          if (coin_ack) begin
            remaining <= remaining - coin_value;
            req_q     <= 1'b0;
            req_d     <= 1'b0;
            req_n     <= 1'b0;
            state     <= S_SELECT;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FAULT: begin
          if (refill) begin
            fault <= 1'b0;
            state <= S_SELECT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, inventory exhaustion,
// fault/refill recovery, illegal credit, and reset/refill collisions.
module tb_change_dispenser;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, coin_ack, refill;
  logic [5:0]       credit;
  logic             req_q, req_d, req_n, busy, done, fault;
  logic [5:0]       remaining;
  logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] RQ = 3'b100, RD = 3'b010, RN = 3'b001, RNONE = 3'b000;

  change_dispenser #(.MAX_COINS(15), .INIT_COINS(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .credit   (credit),
    .coin_ack (coin_ack),
    .refill   (refill),
    .req_q    (req_q),
    .req_d    (req_d),
    .req_n    (req_n),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .remaining(remaining),
    .q_cnt    (q_cnt),
    .d_cnt    (d_cnt),
    .n_cnt    (n_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int q, input int d, input int n);
    chk({tag, " q_cnt"}, 32'(q_cnt), 32'(q));
    chk({tag, " d_cnt"}, 32'(d_cnt), 32'(d));
    chk({tag, " n_cnt"}, 32'(n_cnt), 32'(n));
  endtask

  // Pulse start for one cycle; on return the DUT is in SELECT.
  task automatic do_start(input logic [5:0] c);
    start  = 1'b1;
    credit = c;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [2:0] exp);
    for (int i = 0; i < 10; i++) begin
      if ({req_q, req_d, req_n} != RNONE) break;
      @(negedge clk);
    end
    chk({tag, " req"}, 32'({req_q, req_d, req_n}), 32'(exp));
  endtask

  // Hold one cycle after the request is seen, then acknowledge it.
  task automatic ack_coin(input string tag, input logic [2:0] exp, input int exp_rem);
    @(negedge clk);
    chk({tag, " req held"}, 32'({req_q, req_d, req_n}), 32'(exp));
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    chk({tag, " req cleared"}, 32'({req_q, req_d, req_n}), 32'(RNONE));
    chk({tag, " remaining"}, 32'(remaining), 32'(exp_rem));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; coin_ack = 1'b0; refill = 1'b0; credit = 6'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req", 32'({req_q, req_d, req_n}), 32'(RNONE));
    chk("rst done", 32'(done), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst remaining", 32'(remaining), 32'd0);
    chk_counts("rst", 4, 4, 4);

    // 35 cents from full stock: quarter then dime.
    do_start(6'd35);
    wait_req("c35 q", RQ);
    ack_coin("c35 q", RQ, 10);
    wait_req("c35 d", RD);
    ack_coin("c35 d", RD, 0);
    wait_done("c35");
    chk_counts("c35", 3, 3, 4);

    // Drain the three remaining quarters.
    for (int i = 0; i < 3; i++) begin
      do_start(6'd25);
      wait_req("drain q", RQ);
      ack_coin("drain q", RQ, 0);
      wait_done("drain q");
    end
    chk_counts("drained", 0, 3, 4);

    // No quarters: 30 cents falls back to three dimes.
    do_start(6'd30);
    for (int i = 0; i < 3; i++) begin
      wait_req("c30 d", RD);
      ack_coin("c30 d", RD, 20 - 10 * i);
    end
    wait_done("c30");
    chk_counts("c30", 0, 0, 4);

    // Drain nickels with 20 cents.
    do_start(6'd20);
    for (int i = 0; i < 4; i++) begin
      wait_req("c20 n", RN);
      ack_coin("c20 n", RN, 15 - 5 * i);
    end
    wait_done("c20");
    chk_counts("c20", 0, 0, 0);

    // Empty stock: 15 cents faults; stray ack ignored; refill resumes payout.
    do_start(6'd15);
    @(negedge clk);
    chk("flt fault", 32'(fault), 32'd1);
    chk("flt remaining", 32'(remaining), 32'd15);
    chk("flt req", 32'({req_q, req_d, req_n}), 32'(RNONE));
    chk("flt busy", 32'(busy), 32'd1);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    @(negedge clk);
    chk("flt ack ignored rem", 32'(remaining), 32'd15);
    chk("flt still fault", 32'(fault), 32'd1);
    chk("flt req stays low", 32'({req_q, req_d, req_n}), 32'(RNONE));
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    chk("refill fault clr", 32'(fault), 32'd0);
    chk_counts("refill", 15, 15, 15);
    wait_req("refill d", RD);
    ack_coin("refill d", RD, 5);
    wait_req("refill n", RN);
    ack_coin("refill n", RN, 0);
    wait_done("refill");
    chk_counts("refill end", 15, 14, 14);

    // Zero credit: SELECT then DONE, never a request.
    do_start(6'd0);
    chk("zero sel busy", 32'(busy), 32'd1);
    chk("zero sel done", 32'(done), 32'd0);
    chk("zero sel req", 32'({req_q, req_d, req_n}), 32'(RNONE));
    @(negedge clk);
    chk("zero done", 32'(done), 32'd1);
    chk("zero done busy", 32'(busy), 32'd1);
    chk("zero done req", 32'({req_q, req_d, req_n}), 32'(RNONE));
    @(negedge clk);
    chk("zero after done", 32'(done), 32'd0);
    chk("zero after busy", 32'(busy), 32'd0);

    // Illegal credit is paid as 35; start during DISPENSE is ignored.
    do_start(6'b111111);
    chk("ill remaining", 32'(remaining), 32'd35);
    wait_req("ill q", RQ);
    start  = 1'b1;
    credit = 6'd5;
    @(negedge clk);
    start  = 1'b0;
    chk("busy start rem", 32'(remaining), 32'd35);
    chk("busy start req", 32'({req_q, req_d, req_n}), 32'(RQ));
    ack_coin("ill q", RQ, 10);
    wait_req("ill d", RD);
    ack_coin("ill d", RD, 0);
    wait_done("ill");
    chk_counts("ill", 14, 13, 14);

    // Refill coinciding with a nickel ack.
    do_start(6'd5);
    wait_req("rf+ack n", RN);
    coin_ack = 1'b1;
    refill   = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    refill   = 1'b0;
    chk("rf+ack remaining", 32'(remaining), 32'd0);
    chk_counts("rf+ack", 15, 15, 14);
    wait_done("rf+ack");

    // Reset with a pending ack mid-payout.
    do_start(6'd25);
    wait_req("rst mid q", RQ);
    reset    = 1'b1;
    coin_ack = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    coin_ack = 1'b0;
    chk("rst mid req", 32'({req_q, req_d, req_n}), 32'(RNONE));
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid remaining", 32'(remaining), 32'd0);
    chk_counts("rst mid", 4, 4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
